// File: rtl/poly_tone_gen_if.sv
// Control/status bundle for poly_tone_gen: per-voice note, octave and gate in,
// per-voice wave/active and the registered mix count out.
interface poly_tone_gen_if #(
    parameter int NUM_VOICES = 4,
    parameter int OCT_W      = 2
);
    localparam int MIX_W = $clog2(NUM_VOICES + 1);

    logic [7*NUM_VOICES-1:0]     note_sel;
    logic [OCT_W*NUM_VOICES-1:0] octave;
    logic [NUM_VOICES-1:0]       gate;
    logic [NUM_VOICES-1:0]       wave;
    logic [NUM_VOICES-1:0]       active;
    logic [MIX_W-1:0]            mix;

    modport master (output note_sel, octave, gate, input wave, active, mix);
    modport slave  (input note_sel, octave, gate, output wave, active, mix);
endinterface

// File: rtl/poly_tone_gen.sv
// poly_tone_gen: NUM_VOICES independent square-wave voices plus a registered
// count of voices currently high. Each voice is one poly_tone_voice instance.

// One voice: 2-state FSM with a half-period down-counter. Pitch and gate are
// only sampled on half-period boundaries so pitch changes never make runts.
module poly_tone_voice #(
    parameter int CLK_HZ = 25_000_000,
    parameter int DIV_W  = 20,
    parameter int OCT_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       note_i,
    input  logic [OCT_W-1:0] oct_i,
    input  logic             gate_i,
    output logic             wave_o,
    output logic             active_o
);
    // Base half-periods, CLK_HZ / (2*f) truncated
    localparam logic [DIV_W-1:0] HP_A = DIV_W'(CLK_HZ / 440);
    localparam logic [DIV_W-1:0] HP_B = DIV_W'(CLK_HZ / 494);
    localparam logic [DIV_W-1:0] HP_C = DIV_W'(CLK_HZ / 522);
    localparam logic [DIV_W-1:0] HP_D = DIV_W'(CLK_HZ / 588);
    localparam logic [DIV_W-1:0] HP_E = DIV_W'(CLK_HZ / 660);
    localparam logic [DIV_W-1:0] HP_F = DIV_W'(CLK_HZ / 698);
    localparam logic [DIV_W-1:0] HP_G = DIV_W'(CLK_HZ / 784);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             wave_q, wave_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;

    logic [DIV_W-1:0] hp, n_eff, reload;
    logic             playable;

    // Decode the requested note into its half-period and the reload value
    always_comb begin
        hp = '0;
        case (note_i)
            7'b1000000: hp = HP_A;
            7'b0100000: hp = HP_B;
            7'b0010000: hp = HP_C;
            7'b0001000: hp = HP_D;
            7'b0000100: hp = HP_E;
            7'b0000010: hp = HP_F;
            7'b0000001: hp = HP_G;
            default:    hp = '0;
        endcase
        playable = gate_i && (note_i != 7'd0) && ((note_i & (note_i - 7'd1)) == 7'd0);
        n_eff    = hp >> oct_i;
        if (n_eff == '0) n_eff = DIV_W'(1);
        // The counter holds "cycles left after this one", so a half of N cycles reloads N-1
        reload   = n_eff - DIV_W'(1);
    end

    // State register: FSM state, output level and half-period counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wave_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wave_q  <= wave_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: inputs matter only in IDLE or at a counter boundary in RUN
    always_comb begin
        state_d = state_q;
        wave_d  = wave_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (playable) begin
                    state_d = RUN;
                    wave_d  = 1'b1;
                    cnt_d   = reload;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else if (playable) begin
                    wave_d = ~wave_q;
                    cnt_d  = reload;
                end else begin
                    wave_d  = 1'b0;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                wave_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs straight from registered state
    always_comb begin
        wave_o   = wave_q;
        active_o = (state_q == RUN);
    end
endmodule

module poly_tone_gen #(
    parameter int CLK_HZ     = 25_000_000,
    parameter int NUM_VOICES = 4,
    parameter int DIV_W      = 20,
    parameter int OCT_W      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    poly_tone_gen_if.slave  bus
);
    localparam int MIX_W = $clog2(NUM_VOICES + 1);

    // The longest half-period (A) must fit in the counter
    if ((64'(CLK_HZ) / 64'd440) >= (64'd1 << DIV_W)) begin : g_div_chk
        $error("poly_tone_gen: DIV_W too small for CLK_HZ/440");
    end

    logic [NUM_VOICES-1:0] wave_w, active_w;
    logic [MIX_W-1:0]      mix_q, mix_d;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        poly_tone_voice #(
            .CLK_HZ (CLK_HZ),
            .DIV_W  (DIV_W),
            .OCT_W  (OCT_W)
        ) u_voice (
            .clk      (clk),
            .rst_n    (rst_n),
            .note_i   (bus.note_sel[7*v +: 7]),
            .oct_i    (bus.octave[OCT_W*v +: OCT_W]),
            .gate_i   (bus.gate[v]),
            .wave_o   (wave_w[v]),
            .active_o (active_w[v])
        );
    end

    // Population count of voices currently high
    always_comb begin
        mix_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) mix_d = mix_d + MIX_W'(wave_w[i]);
    end

    // Mix register, one cycle behind wave
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mix_q <= '0;
        else        mix_q <= mix_d;
    end

    assign bus.wave   = wave_w;
    assign bus.active = active_w;
    assign bus.mix    = mix_q;
endmodule

// File: tb/tb_poly_tone_gen.sv
// Bench for poly_tone_gen: table of single-voice half-period measurements,
// hand sequences for pitch change / release / reset corners, then random
// stimulus compared cycle by cycle against a behavioural voice model.
module tb_poly_tone_gen;
    localparam int CLK_HZ = 250_000;   // scaled clock keeps periods short
    localparam int NV     = 4;
    localparam int DIV_W  = 20;
    localparam int OCT_W  = 2;

    localparam logic [6:0] N_A = 7'b1000000, N_B = 7'b0100000, N_C = 7'b0010000,
                           N_D = 7'b0001000, N_E = 7'b0000100, N_F = 7'b0000010,
                           N_G = 7'b0000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    poly_tone_gen_if #(.NUM_VOICES(NV), .OCT_W(OCT_W)) bus();

    poly_tone_gen #(.CLK_HZ(CLK_HZ), .NUM_VOICES(NV), .DIV_W(DIV_W), .OCT_W(OCT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: note frequencies indexed by note_sel bit (0=G .. 6=A)
    int FREQ[7] = '{392, 349, 330, 294, 261, 247, 220};
    bit snd_m[NV];
    bit lvl_m[NV];
    int rem_m[NV];
    int mix_m;

    function automatic int half_len(logic [6:0] note, logic [OCT_W-1:0] oct);
        int f = 1;
        int n;
        for (int i = 0; i < 7; i++) if (note[i]) f = FREQ[i];
        n = (CLK_HZ / (2 * f)) >> oct;
        if (n == 0) n = 1;
        return n;
    endfunction

    function automatic bit can_play(int v);
        logic [6:0] nt = bus.note_sel[7*v +: 7];
        return bus.gate[v] && ($countones(nt) == 1);
    endfunction

    function automatic int cur_len(int v);
        return half_len(bus.note_sel[7*v +: 7], bus.octave[OCT_W*v +: OCT_W]);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < NV; v++) begin
            snd_m[v] = 0; lvl_m[v] = 0; rem_m[v] = 0;
        end
        mix_m = 0;
    endtask

    // One clock: advance the model with the inputs sampled at the edge, then compare
    task automatic tick();
        int pc;
        @(posedge clk);
        pc = 0;
        for (int v = 0; v < NV; v++) pc += int'(lvl_m[v]);
        if (!rst_n) model_clear();
        else begin
            mix_m = pc;
            for (int v = 0; v < NV; v++) begin
                if (!snd_m[v]) begin
                    if (can_play(v)) begin
                        snd_m[v] = 1; lvl_m[v] = 1; rem_m[v] = cur_len(v);
                    end
                end else begin
                    rem_m[v]--;
                    if (rem_m[v] == 0) begin
                        if (can_play(v)) begin
                            lvl_m[v] = ~lvl_m[v]; rem_m[v] = cur_len(v);
                        end else begin
                            snd_m[v] = 0; lvl_m[v] = 0;
                        end
                    end
                end
            end
        end
        #1;
        for (int v = 0; v < NV; v++) begin
            chk($sformatf("wave%0d", v), int'(bus.wave[v]), int'(lvl_m[v]));
            chk($sformatf("active%0d", v), int'(bus.active[v]), int'(snd_m[v]));
        end
        chk("mix", int'(bus.mix), mix_m);
    endtask

    task automatic set_v(int v, logic [6:0] n, logic [OCT_W-1:0] o, logic g);
        bus.note_sel[7*v +: 7]       = n;
        bus.octave[OCT_W*v +: OCT_W] = o;
        bus.gate[v]                  = g;
    endtask

    // Ticks until voice v leaves level lvl; call right after it entered lvl
    task automatic count_level(int v, logic lvl, output int n);
        n = 0;
        do begin
            n++;
            tick();
        end while (bus.wave[v] == lvl && n < 5000);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.active != '0 && n < 3000) begin
            tick();
            n++;
        end
        chk("idle_reached", int'(bus.active == '0), 1);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_wave", int'(bus.wave), 0);
        chk("rst_active", int'(bus.active), 0);
        chk("rst_mix", int'(bus.mix), 0);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int               v;
        logic [6:0]       note;
        logic [OCT_W-1:0] oct;
        int               half;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n, mx;
        vecs[0]  = '{0, N_A, 2'd0, 568};
        vecs[1]  = '{0, N_A, 2'd1, 284};
        vecs[2]  = '{0, N_A, 2'd2, 142};
        vecs[3]  = '{0, N_A, 2'd3, 71};
        vecs[4]  = '{1, N_B, 2'd0, 506};
        vecs[5]  = '{2, N_C, 2'd0, 478};
        vecs[6]  = '{3, N_D, 2'd0, 425};
        vecs[7]  = '{1, N_E, 2'd0, 378};
        vecs[8]  = '{2, N_F, 2'd0, 358};
        vecs[9]  = '{3, N_G, 2'd0, 318};
        vecs[10] = '{0, N_G, 2'd3, 39};
        vecs[11] = '{1, N_C, 2'd2, 119};

        model_clear();
        bus.note_sel = {NV{N_A}};
        bus.octave   = '0;
        bus.gate     = '1;
        rst_n        = 1'b0;

        // Held in reset with gates up: everything stays zero
        repeat (5) tick();
        chk("hold_rst_wave", int'(bus.wave), 0);
        rst_n = 1'b1;
        tick();
        chk("start_all", int'(bus.wave), 15);
        bus.gate = '0;
        wait_idle();

        // Table: half-period lengths per note/octave/voice
        foreach (vecs[i]) begin
            set_v(vecs[i].v, vecs[i].note, vecs[i].oct, 1'b1);
            tick();
            chk($sformatf("vec%0d_rise", i), int'(bus.wave[vecs[i].v]), 1);
            count_level(vecs[i].v, 1'b1, n);
            chk($sformatf("vec%0d_high", i), n, vecs[i].half);
            count_level(vecs[i].v, 1'b0, n);
            chk($sformatf("vec%0d_low", i), n, vecs[i].half);
            bus.gate[vecs[i].v] = 1'b0;
            wait_idle();
        end

        // Pitch change mid high half: current half keeps A, then G
        set_v(0, N_A, 2'd0, 1'b1);
        tick();
        repeat (20) tick();
        set_v(0, N_G, 2'd0, 1'b1);
        count_level(0, 1'b1, n);
        chk("pc_old_half", 20 + n, 568);
        count_level(0, 1'b0, n);
        chk("pc_new_low", n, 318);
        count_level(0, 1'b1, n);
        chk("pc_new_high", n, 318);
        bus.gate[0] = 1'b0;
        wait_idle();

        // Release during high half: the high half completes
        set_v(0, N_A, 2'd1, 1'b1);
        tick();
        repeat (10) tick();
        bus.gate[0] = 1'b0;
        count_level(0, 1'b1, n);
        chk("rel_hi_len", 10 + n, 284);
        chk("rel_hi_idle", int'(bus.active[0]), 0);

        // Release during low half: idle at its boundary with no extra pulse
        set_v(0, N_A, 2'd1, 1'b1);
        tick();
        count_level(0, 1'b1, n);
        repeat (5) tick();
        bus.gate[0] = 1'b0;
        n = 0;
        while (bus.active[0] && n < 2000) begin
            tick();
            n++;
            if (bus.active[0]) chk("rel_lo_wave", int'(bus.wave[0]), 0);
        end
        chk("rel_lo_len", 5 + n, 284);

        // Re-gate right after returning to idle
        set_v(0, N_A, 2'd3, 1'b1);
        tick();
        repeat (5) tick();
        bus.gate[0] = 1'b0;
        count_level(0, 1'b1, n);
        chk("regate_idle", int'(bus.active[0]), 0);
        bus.gate[0] = 1'b1;
        tick();
        chk("regate_rise", int'(bus.wave[0]), 1);
        bus.gate[0] = 1'b0;
        wait_idle();

        // Multi-hot and zero-hot notes never start
        set_v(0, 7'b1000001, 2'd0, 1'b1);
        repeat (20) tick();
        chk("multihot_idle", int'(bus.active[0]), 0);
        set_v(0, 7'b0000000, 2'd0, 1'b1);
        repeat (20) tick();
        chk("zerohot_idle", int'(bus.active[0]), 0);
        bus.gate[0] = 1'b0;

        // Chord A/C/E/G, mix peaks at 4, then reset mid-tone
        set_v(0, N_A, 2'd0, 1'b1);
        set_v(1, N_C, 2'd0, 1'b1);
        set_v(2, N_E, 2'd0, 1'b1);
        set_v(3, N_G, 2'd0, 1'b1);
        mx = 0;
        repeat (1500) begin
            tick();
            if (int'(bus.mix) > mx) mx = int'(bus.mix);
        end
        chk("mix_max", mx, 4);
        async_reset();
        tick();
        chk("post_rst_start", int'(bus.wave), 15);
        bus.gate = '0;
        wait_idle();

        // Random stimulus against the model
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 29) == 0) begin
                int v = int'($urandom_range(0, NV - 1));
                logic [6:0] nt;
                if ($urandom_range(0, 9) < 8) nt = 7'd1 << $urandom_range(0, 6);
                else                          nt = 7'($urandom);
                set_v(v, nt, OCT_W'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 2499) == 0) async_reset();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
